// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of requester-side and memory-side signals around the
//               unified-memory arbiter. The slave modport is the arbiter's
//               view; the master modport is the view of everything around it.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
  // Instruction fetch port
  logic        fe_req;
  logic [31:0] fe_addr;
  logic        fe_ack;
  logic        fe_rvalid;
  logic [31:0] fe_rdata;
  // Data-memory stage port
  logic        dm_req;
  logic [31:0] dm_addr;
  logic        dm_write;
  logic [31:0] dm_wdata;
  logic [1:0]  dm_width;
  logic        dm_extend;
  logic        dm_ack;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  // DMA / debug loader port
  logic        dma_req;
  logic [31:0] dma_addr;
  logic        dma_write;
  logic [31:0] dma_wdata;
  logic        dma_ack;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  // Memory request port
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_width;
  logic        mem_extend;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  fe_req, fe_addr,
    output fe_ack, fe_rvalid, fe_rdata,
    input  dm_req, dm_addr, dm_write, dm_wdata, dm_width, dm_extend,
    output dm_ack, dm_rvalid, dm_rdata,
    input  dma_req, dma_addr, dma_write, dma_wdata,
    output dma_ack, dma_rvalid, dma_rdata,
    output mem_req, mem_addr, mem_write, mem_wdata, mem_width, mem_extend,
    input  mem_ack, mem_rdata
  );

  modport master (
    output fe_req, fe_addr,
    input  fe_ack, fe_rvalid, fe_rdata,
    output dm_req, dm_addr, dm_write, dm_wdata, dm_width, dm_extend,
    input  dm_ack, dm_rvalid, dm_rdata,
    output dma_req, dma_addr, dma_write, dma_wdata,
    input  dma_ack, dma_rvalid, dma_rdata,
    input  mem_req, mem_addr, mem_write, mem_wdata, mem_width, mem_extend,
    output mem_ack, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Three-way arbiter (fetch, data stage, DMA) in front of the
//               single-ported unified memory. Fixed priority dm > fe > dma
//               with starvation promotion of fe/dma, and one-cycle routing of
//               read data back to the requester that issued the read.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_FE   = 2'd1,
    OWN_DM   = 2'd2,
    OWN_DMA  = 2'd3
  } owner_e;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] fe_cnt_q, fe_cnt_d;
  logic [CNT_W-1:0] dma_cnt_q, dma_cnt_d;
  owner_e           rd_owner_q, rd_owner_d;
  owner_e           gnt;
  logic [31:0]      fe_rdata_q, dm_rdata_q, dma_rdata_q;
  logic             fe_starved, dma_starved;
  logic             fe_own, dm_own, dma_own;

  // Pick this cycle's grantee: starved fe, then starved dma, then dm > fe > dma.
  always_comb begin
    gnt         = OWN_NONE;
    fe_starved  = (fe_cnt_q == LIMIT) && bus.fe_req;
    dma_starved = (dma_cnt_q == LIMIT) && bus.dma_req;
    if (reset_n) begin
      if (fe_starved)       gnt = OWN_FE;
      else if (dma_starved) gnt = OWN_DMA;
      else if (bus.dm_req)  gnt = OWN_DM;
      else if (bus.fe_req)  gnt = OWN_FE;
      else if (bus.dma_req) gnt = OWN_DMA;
    end
  end

  // Forward the grantee's request fields and hand mem_ack back to it alone.
  always_comb begin
    bus.mem_req    = reset_n && (bus.fe_req || bus.dm_req || bus.dma_req);
    bus.mem_addr   = 32'd0;
    bus.mem_write  = 1'b0;
    bus.mem_wdata  = 32'd0;
    bus.mem_width  = 2'b00;
    bus.mem_extend = 1'b0;
    case (gnt)
      OWN_FE: begin
        bus.mem_addr  = bus.fe_addr;
        bus.mem_width = 2'b10;
      end
      OWN_DM: begin
        bus.mem_addr   = bus.dm_addr;
        bus.mem_write  = bus.dm_write;
        bus.mem_wdata  = bus.dm_wdata;
        bus.mem_width  = bus.dm_width;
        bus.mem_extend = bus.dm_extend;
      end
      OWN_DMA: begin
        bus.mem_addr  = bus.dma_addr;
        bus.mem_write = bus.dma_write;
        bus.mem_wdata = bus.dma_wdata;
        bus.mem_width = 2'b10;
      end
      default: ;
    endcase
    bus.fe_ack  = (gnt == OWN_FE)  && bus.mem_ack;
    bus.dm_ack  = (gnt == OWN_DM)  && bus.mem_ack;
    bus.dma_ack = (gnt == OWN_DMA) && bus.mem_ack;
  end

  // Next-state for starvation counters and the owner of the read in flight.
  always_comb begin
    fe_cnt_d   = '0;
    dma_cnt_d  = '0;
    rd_owner_d = OWN_NONE;
    if (bus.fe_req && !bus.fe_ack)
      fe_cnt_d = (fe_cnt_q == LIMIT) ? LIMIT : fe_cnt_q + ONE;
    if (bus.dma_req && !bus.dma_ack)
      dma_cnt_d = (dma_cnt_q == LIMIT) ? LIMIT : dma_cnt_q + ONE;
    if (bus.mem_req && bus.mem_ack && !bus.mem_write)
      rd_owner_d = gnt;
  end

  // State register; reset drops any read in flight and clears the counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fe_cnt_q   <= '0;
      dma_cnt_q  <= '0;
      rd_owner_q <= OWN_NONE;
    end else begin
      fe_cnt_q   <= fe_cnt_d;
      dma_cnt_q  <= dma_cnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Per-requester hold registers keep the last delivered read word visible.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fe_rdata_q  <= 32'd0;
      dm_rdata_q  <= 32'd0;
      dma_rdata_q <= 32'd0;
    end else begin
      if (rd_owner_q == OWN_FE)  fe_rdata_q  <= bus.mem_rdata;
      if (rd_owner_q == OWN_DM)  dm_rdata_q  <= bus.mem_rdata;
      if (rd_owner_q == OWN_DMA) dma_rdata_q <= bus.mem_rdata;
    end
  end

  // Route the returning read word to its owner; others see their held value.
  always_comb begin
    fe_own         = reset_n && (rd_owner_q == OWN_FE);
    dm_own         = reset_n && (rd_owner_q == OWN_DM);
    dma_own        = reset_n && (rd_owner_q == OWN_DMA);
    bus.fe_rvalid  = fe_own;
    bus.dm_rvalid  = dm_own;
    bus.dma_rvalid = dma_own;
    bus.fe_rdata   = fe_own  ? bus.mem_rdata : fe_rdata_q;
    bus.dm_rdata   = dm_own  ? bus.mem_rdata : dm_rdata_q;
    bus.dma_rdata  = dma_own ? bus.mem_rdata : dma_rdata_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A reference grant model
//               predicts acks and forwarded fields; accepted reads push the
//               expected owner/data into a queue that is popped when the
//               read data is due one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int          STARVE_LIMIT = 8;
  localparam int          CNT_W        = 4;
  localparam logic [31:0] JUNK         = 32'h0BAD_F00D;
  localparam logic [2:0]  A_FE         = 3'b100;
  localparam logic [2:0]  A_DM         = 3'b010;
  localparam logic [2:0]  A_DMA        = 3'b001;

  typedef struct packed {
    logic [2:0]  who;
    logic [31:0] data;
  } rd_exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  rd_exp_t     exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          m_fe_cnt = 0;
  int          m_dma_cnt = 0;
  logic [31:0] last_fe = 32'd0, last_dm = 32'd0, last_dma = 32'd0;
  logic [31:0] next_rdata = JUNK;
  logic [2:0]  obs_ack = 3'b000;
  logic [2:0]  obs_rv = 3'b000;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Contents of the memory as seen by reads.
  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Evaluated at the falling edge, with inputs stable for this cycle.
  task automatic evaluate();
    rd_exp_t     e;
    rd_exp_t     n;
    logic [2:0]  exp_rv, exp_gnt, exp_ack;
    logic [31:0] ea, ewd;
    logic        ew, eext;
    logic [1:0]  ewid;

    obs_rv     = {bus.fe_rvalid, bus.dm_rvalid, bus.dma_rvalid};
    obs_ack    = {bus.fe_ack, bus.dm_ack, bus.dma_ack};
    next_rdata = JUNK;

    if (!reset_n) begin
      check("rst_mem_req", 32'(bus.mem_req), 32'd0);
      check("rst_acks", 32'(obs_ack), 32'd0);
      check("rst_rvalid", 32'(obs_rv), 32'd0);
      exp_q.delete();
      m_fe_cnt  = 0;
      m_dma_cnt = 0;
      last_fe   = 32'd0;
      last_dm   = 32'd0;
      last_dma  = 32'd0;
      return;
    end

    // Read data due this cycle
    exp_rv = 3'b000;
    e      = '0;
    if (exp_q.size() > 0) begin
      e      = exp_q.pop_front();
      exp_rv = e.who;
    end
    check("rvalid", 32'(obs_rv), 32'(exp_rv));
    if (exp_rv[2]) last_fe  = e.data;
    if (exp_rv[1]) last_dm  = e.data;
    if (exp_rv[0]) last_dma = e.data;
    check("fe_rdata", bus.fe_rdata, last_fe);
    check("dm_rdata", bus.dm_rdata, last_dm);
    check("dma_rdata", bus.dma_rdata, last_dma);

    // Reference grant
    exp_gnt = 3'b000;
    if (m_fe_cnt == STARVE_LIMIT && bus.fe_req)        exp_gnt = A_FE;
    else if (m_dma_cnt == STARVE_LIMIT && bus.dma_req) exp_gnt = A_DMA;
    else if (bus.dm_req)                               exp_gnt = A_DM;
    else if (bus.fe_req)                               exp_gnt = A_FE;
    else if (bus.dma_req)                              exp_gnt = A_DMA;
    exp_ack = bus.mem_ack ? exp_gnt : 3'b000;
    check("acks", 32'(obs_ack), 32'(exp_ack));
    check("mem_req", 32'(bus.mem_req), 32'(bus.fe_req | bus.dm_req | bus.dma_req));

    ea = 32'd0; ew = 1'b0; ewd = 32'd0; ewid = 2'b10; eext = 1'b0;
    case (exp_gnt)
      A_FE:  begin ea = bus.fe_addr; end
      A_DM:  begin ea = bus.dm_addr; ew = bus.dm_write; ewd = bus.dm_wdata;
                   ewid = bus.dm_width; eext = bus.dm_extend; end
      A_DMA: begin ea = bus.dma_addr; ew = bus.dma_write; ewd = bus.dma_wdata; end
      default: ;
    endcase
    if (exp_gnt != 3'b000) begin
      check("mem_addr", bus.mem_addr, ea);
      check("mem_write", 32'(bus.mem_write), 32'(ew));
      check("mem_wdata", bus.mem_wdata, ewd);
      check("mem_width", 32'(bus.mem_width), 32'(ewid));
      check("mem_extend", 32'(bus.mem_extend), 32'(eext));
    end

    if (exp_ack != 3'b000 && !ew) begin
      n.who  = exp_ack;
      n.data = memval(ea);
      exp_q.push_back(n);
      next_rdata = n.data;
    end

    m_fe_cnt  = (bus.fe_req && !exp_ack[2]) ?
                ((m_fe_cnt == STARVE_LIMIT) ? STARVE_LIMIT : m_fe_cnt + 1) : 0;
    m_dma_cnt = (bus.dma_req && !exp_ack[0]) ?
                ((m_dma_cnt == STARVE_LIMIT) ? STARVE_LIMIT : m_dma_cnt + 1) : 0;
  endtask

  // One clock cycle: check at the falling edge, then let the memory answer.
  task automatic step();
    @(negedge clk);
    evaluate();
    @(posedge clk);
    #1;
    bus.mem_rdata = next_rdata;
  endtask

  initial begin
    int waited;
    int first_dma;
    int dma_acks;
    int collisions;
    logic fe_got;

    bus.fe_req    = 1'b0; bus.fe_addr  = 32'd0;
    bus.dm_req    = 1'b0; bus.dm_addr  = 32'd0; bus.dm_write = 1'b0;
    bus.dm_wdata  = 32'd0; bus.dm_width = 2'b10; bus.dm_extend = 1'b0;
    bus.dma_req   = 1'b0; bus.dma_addr = 32'd0; bus.dma_write = 1'b0;
    bus.dma_wdata = 32'd0;
    bus.mem_ack   = 1'b1; bus.mem_rdata = JUNK;

    // Reset
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    check("rst_fe_cnt", 32'(dut.fe_cnt_q), 32'd0);
    check("rst_dma_cnt", 32'(dut.dma_cnt_q), 32'd0);
    check("rst_owner", 32'(dut.rd_owner_q), 32'd0);

    // Single fetch read
    bus.fe_req = 1'b1; bus.fe_addr = 32'h100;
    step();
    check("t1_fe_ack", 32'(obs_ack), 32'(A_FE));
    bus.fe_req = 1'b0;
    step();
    check("t1_fe_rvalid", 32'(obs_rv), 32'(A_FE));
    check("t1_fe_rdata", last_fe, 32'hDEAD_BEEF);

    // fe and dm together: dm first, fe next cycle
    bus.fe_req = 1'b1; bus.fe_addr = 32'h104;
    bus.dm_req = 1'b1; bus.dm_addr = 32'h204; bus.dm_write = 1'b0;
    bus.dm_width = 2'b01; bus.dm_extend = 1'b1;
    step();
    check("t2_dm_first", 32'(obs_ack), 32'(A_DM));
    bus.dm_req = 1'b0;
    step();
    check("t2_fe_second", 32'(obs_ack), 32'(A_FE));
    check("t2_dm_rvalid", 32'(obs_rv), 32'(A_DM));
    bus.fe_req = 1'b0;
    step();
    check("t2_fe_rvalid", 32'(obs_rv), 32'(A_FE));

    // dm held continuously starves fe until promotion
    bus.dm_req = 1'b1; bus.dm_addr = 32'h208; bus.dm_width = 2'b10; bus.dm_extend = 1'b0;
    bus.fe_req = 1'b1; bus.fe_addr = 32'h300;
    waited = 0;
    fe_got = 1'b0;
    for (int i = 0; i < 20 && !fe_got; i++) begin
      step();
      if (obs_ack == A_FE) fe_got = 1'b1;
      else waited++;
    end
    check("t3_fe_got", 32'(fe_got), 32'd1);
    check("t3_fe_wait", 32'(waited), 32'(STARVE_LIMIT));
    check("t3_fe_cnt_clr", 32'(dut.fe_cnt_q), 32'd0);
    bus.fe_req = 1'b0;
    step();
    check("t3_dm_after", 32'(obs_ack), 32'(A_DM));
    bus.dm_req = 1'b0;
    step();

    // All three requesters held for 20 cycles
    bus.fe_req  = 1'b1; bus.fe_addr  = 32'h400;
    bus.dm_req  = 1'b1; bus.dm_addr  = 32'h500;
    bus.dma_req = 1'b1; bus.dma_addr = 32'h600; bus.dma_write = 1'b0;
    first_dma  = 0;
    dma_acks   = 0;
    collisions = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if ($countones(obs_ack) > 1) collisions++;
      if (obs_ack == A_DMA) begin
        dma_acks++;
        if (first_dma == 0) first_dma = i;
      end
    end
    check("t4_dma_first", 32'(first_dma), 32'd10);
    check("t4_dma_acks", 32'(dma_acks), 32'd2);
    check("t4_collisions", 32'(collisions), 32'd0);
    bus.fe_req = 1'b0; bus.dm_req = 1'b0; bus.dma_req = 1'b0;
    step();

    // Memory stalls with dm pending
    bus.dm_req = 1'b1; bus.dm_addr = 32'h700;
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_no_ack", 32'(obs_ack), 32'd0);
    end
    check("t5_fe_cnt", 32'(dut.fe_cnt_q), 32'd0);
    check("t5_dma_cnt", 32'(dut.dma_cnt_q), 32'd0);
    bus.mem_ack = 1'b1;
    step();
    bus.dm_req = 1'b0;
    step();

    // dma read, dm write behind it, then reset with a read in flight
    bus.dma_req = 1'b1; bus.dma_addr = 32'h40; bus.dma_write = 1'b0;
    step();
    check("t6_dma_ack", 32'(obs_ack), 32'(A_DMA));
    bus.dma_req = 1'b0;
    bus.dm_req = 1'b1; bus.dm_addr = 32'h80; bus.dm_write = 1'b1;
    bus.dm_wdata = 32'h1234_5678; bus.dm_width = 2'b10;
    step();
    check("t6_dm_wr_ack", 32'(obs_ack), 32'(A_DM));
    check("t6_dma_rvalid", 32'(obs_rv), 32'(A_DMA));
    bus.dm_write = 1'b0; bus.dm_addr = 32'h84;
    bus.fe_req = 1'b1; bus.fe_addr = 32'h88;
    step();
    check("t6_no_wr_rvalid", 32'(obs_rv), 32'd0);
    check("t6_fe_cnt_up", 32'(dut.fe_cnt_q), 32'd1);
    bus.dm_req = 1'b0;
    reset_n = 1'b0;
    step();
    check("t6_rst_drop", 32'(obs_rv), 32'd0);
    step();
    reset_n = 1'b1;
    check("t6_fe_cnt_rst", 32'(dut.fe_cnt_q), 32'd0);
    check("t6_dma_cnt_rst", 32'(dut.dma_cnt_q), 32'd0);
    check("t6_owner_rst", 32'(dut.rd_owner_q), 32'd0);
    bus.fe_req = 1'b0;
    step();
    check("t6_post_rst_rv", 32'(obs_rv), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported unified memory between three requesters: instruction fetch (fe), the data-memory stage (dm) and a DMA/debug loader (dma).
- Selects one request per cycle using fixed priority with starvation escape.
- Forwards the selected request to the memory's request port.
- Tracks the owner of each in-flight read and routes the returned read data, one cycle later, to that owner only.
- Sits between the pipeline/loader and the memory block.

Parameters:
- STARVE_LIMIT, 8: consecutive unserved cycles after which fe or dma is promoted to top priority.
- CNT_W, 4: width of the starvation counters; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- fe_req  in  1  fetch read request; held until fe_ack
- fe_addr  in  32  fetch word address
- fe_ack  out  1  fetch request accepted this cycle
- fe_rvalid  out  1  fe_rdata valid (cycle after accepted fetch)
- fe_rdata  out  32  fetch read data
- dm_req  in  1  data request; held until dm_ack
- dm_addr  in  32  data byte address
- dm_write  in  1  1 = store, 0 = load
- dm_wdata  in  32  store data
- dm_width  in  2  00 byte, 01 half, 1x word
- dm_extend  in  1  sign-extend loads
- dm_ack  out  1  data request accepted this cycle
- dm_rvalid  out  1  dm_rdata valid
- dm_rdata  out  32  load data
- dma_req  in  1  DMA request; held until dma_ack
- dma_addr  in  32  DMA word address
- dma_write  in  1  1 = word write, 0 = word read
- dma_wdata  in  32  DMA write data
- dma_ack  out  1  DMA request accepted this cycle
- dma_rvalid  out  1  dma_rdata valid
- dma_rdata  out  32  DMA read data
- mem_req  out  1  request to memory
- mem_addr  out  32  forwarded address
- mem_write  out  1  forwarded write flag
- mem_wdata  out  32  forwarded write data
- mem_width  out  2  forwarded width
- mem_extend  out  1  forwarded extend
- mem_ack  in  1  memory accepted mem_req this cycle
- mem_rdata  in  32  memory read data, valid the cycle after an accepted read

Behaviour:
- Reset: reset_n is sampled on rising clk (synchronous, active-low).
  - While reset_n is low: mem_req=0; all *_ack=0; all *_rvalid=0.
  - Registered state after reset: fe_cnt=0, dma_cnt=0, rd_owner=NONE.
- Grant selection (combinational, each cycle). Base priority is dm > fe > dma. Override order:
  - If fe_cnt==STARVE_LIMIT and fe_req: grant fe.
  - Else if dma_cnt==STARVE_LIMIT and dma_req: grant dma.
  - Else base priority.
  - If fe and dma are both starved, fe wins.
  - A starved requester never preempts a request already acknowledged; acks are per-cycle, so there is no mid-transaction preemption.
- Forwarding:
  - mem_req = any req (while out of reset); mem_* fields come from the granted requester.
  - For fe: mem_write=0, mem_width=2'b10, mem_extend=0, mem_wdata=0.
  - For dma: mem_width=2'b10, mem_extend=0.
  - Grantee's ack = mem_ack. Non-grantees' ack = 0. An ack is never asserted without mem_ack.
- Starvation counters (fe_cnt, dma_cnt, registered):
  - Increment when the requester's req=1 and its ack=0.
  - Saturate at STARVE_LIMIT.
  - Clear to 0 when the requester is acked or its req=0.
- Read routing:
  - On a cycle with an accepted read (mem_req & mem_ack & ~mem_write), rd_owner is set to the grantee; otherwise rd_owner=NONE.
  - Next cycle: owner's *_rvalid=1, owner's *_rdata=mem_rdata.
  - Non-owners: rvalid=0, rdata holds its last delivered value (registered hold, cleared to 0 at reset).
  - Back-to-back accepted reads to different owners route correctly every cycle; latency is exactly 1 cycle; throughput is 1 access per cycle.
- Writes: produce no rvalid. A write accepted in the cycle after a read does not disturb delivery of that read's data.
- Reset mid-operation: an in-flight read is dropped (no rvalid after reset); counters are cleared.
- Requesters must hold address and data stable until ack; the arbiter does not latch request fields.

Test Plan:
- Reset, then fe_req=1 with fe_addr=0x100, mem_ack=1, mem_rdata=0xDEADBEEF the next cycle -> fe_ack=1 in cycle 0; fe_rvalid=1, fe_rdata=0xDEADBEEF in cycle 1; dm_rvalid and dma_rvalid stay 0.
- fe_req and dm_req (load, addr 0x204, width 01) together -> dm_ack=1, fe_ack=0, mem_width=01, mem_addr=0x204; fe acked the following cycle; dm_rvalid precedes fe_rvalid by one cycle.
- dm_req held high continuously with fe_req high, STARVE_LIMIT=8 -> fe_ack=0 for 8 cycles, fe_ack=1 in cycle 9, fe_cnt=0 afterwards; dm is acked again in cycle 10.
- fe, dm and dma all held high for 20 cycles -> dma is acked only after reaching starvation (fe starved first wins ties); no two acks are ever high in one cycle.
- mem_ack=0 for 3 cycles with dm_req=1 -> dm_ack=0 for those cycles; no rvalid; fe_cnt and dma_cnt unchanged when their reqs are low.
- Accepted dma read followed by a dm write (dm_write=1, dm_wdata=0x12345678), then reset_n=0 with a read in flight -> dma_rvalid asserted for the read, no rvalid for the write; no rvalid after reset; all counters 0.
